// File: rtl/dsp_cfg_pkg.sv
// Shared types and constants for the DSP slice configuration chain loader.
// Chain-length default lives beside the slice's own chain-length constant.
package dsp_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } cfg_state_e;

  localparam int DSP_SLICE_CFG_BITS       = 64;
  localparam int CFG_CHAIN_LENGTH_DEFAULT = DSP_SLICE_CFG_BITS;
  localparam int CFG_WORD_WIDTH_DEFAULT   = 16;

  // Counter wide enough to hold the value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dsp_config_chain_loader.sv
// Serialises valid/ready config words LSB-first into the DSP chain; every output is a flop.
// Word taken on edge N shows bit 0 in cycle N+1; one bubble per word, cfg_valid stalls hold the chain idle.
module dsp_config_chain_loader
  import dsp_cfg_pkg::*;
#(
  parameter int CHAIN_LENGTH = CFG_CHAIN_LENGTH_DEFAULT,
  parameter int WORD_WIDTH   = CFG_WORD_WIDTH_DEFAULT,
  parameter int CNT_W        = cnt_width(CHAIN_LENGTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] cfg_word,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  configuration_input,
  output logic                  configuration_enable,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      bit_count
);

  localparam int WCNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  cfg_state_e             state_q, state_d;
  logic [WORD_WIDTH-1:0]  sreg_q, sreg_d;
  logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
  logic [CNT_W-1:0]       bit_count_q, bit_count_d;
  logic                   cfg_ready_q, cfg_ready_d;
  logic                   cfg_in_q, cfg_in_d;
  logic                   cfg_en_q, cfg_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic accept;
  logic last_chain_bit;
  logic last_word_bit;

  assign accept         = (state_q == LOAD) && !abort && cfg_valid && cfg_ready_q;
  assign last_chain_bit = (bit_count_q == CNT_W'(CHAIN_LENGTH - 1));
  assign last_word_bit  = (wcnt_q == WCNT_W'(WORD_WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Chain end outranks word end, so a partial last word's high bits are dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) state_d = LOAD;
      end
      LOAD: begin
        if (abort)       state_d = IDLE;
        else if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (abort)               state_d = IDLE;
        else if (last_chain_bit) state_d = DONE;
        else if (last_word_bit)  state_d = LOAD;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered copies of what the next state presents.
  always_comb begin
    cfg_ready_d = (state_d == LOAD);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    cfg_en_d    = (state_d == SHIFT);
    cfg_in_d    = (state_d == SHIFT) ? sreg_d[0] : 1'b0;
  end

  always_comb begin
    sreg_d      = sreg_q;
    wcnt_d      = wcnt_q;
    bit_count_d = bit_count_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) bit_count_d = '0;
      end
      LOAD: begin
        if (accept) begin
          sreg_d = cfg_word;
          wcnt_d = '0;
        end
      end
      SHIFT: begin
        // An abort freezes the count at the last value reported.
        if (!abort) begin
          sreg_d      = sreg_q >> 1;
          wcnt_d      = wcnt_q + 1'b1;
          bit_count_d = bit_count_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg_q      <= '0;
      wcnt_q      <= '0;
      bit_count_q <= '0;
      cfg_ready_q <= 1'b0;
      cfg_in_q    <= 1'b0;
      cfg_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sreg_q      <= sreg_d;
      wcnt_q      <= wcnt_d;
      bit_count_q <= bit_count_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_in_q    <= cfg_in_d;
      cfg_en_q    <= cfg_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cfg_ready            = cfg_ready_q;
  assign configuration_input  = cfg_in_q;
  assign configuration_enable = cfg_en_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign bit_count            = bit_count_q;

endmodule

// File: doc/dsp_config_chain_loader.md
Name: dsp_config_chain_loader

Overview:
- Upstream feeder of the DSP slice's serial configuration chain, i.e. the `configuration_input` / `configuration_enable` pins of the DSP top level.
- Accepts configuration words over a valid/ready handshake and serialises them LSB-first.
- Shifts exactly CHAIN_LENGTH bits into the chain, then reports completion.
- Lets a controller (host, ROM sequencer or test bench) program every slice's mode bits without hand-toggling the chain.

Parameters:
- CHAIN_LENGTH, 64: total configuration bits in the downstream chain; must be ≥ 1.
- WORD_WIDTH, 16: width of each incoming configuration word; must be ≥ 1.
- CNT_W, $clog2(CHAIN_LENGTH+1): width of bit_count (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock, shared with the DSP slice.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a load; sampled in IDLE only.
- abort  input  1  cancels an active load; return to IDLE.
- cfg_word  input  WORD_WIDTH  configuration data; bit 0 is shifted first.
- cfg_valid  input  1  cfg_word is valid.
- cfg_ready  output  1  loader can accept a word this cycle.
- configuration_input  output  1  serial bit to the chain head.
- configuration_enable  output  1  chain shift enable; high only while a valid bit is presented.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the final chain bit is shifted.
- bit_count  output  CNT_W  bits shifted so far in the current load.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - configuration_input=0, configuration_enable=0, cfg_ready=0, busy=0, done=0, bit_count=0.
  - Shift register and word bit counter cleared.
- All outputs are registered. No combinational path from input to output.
- States:
  - IDLE: start=1 → LOAD; bit_count cleared to 0 on that edge.
  - LOAD: cfg_ready=1, configuration_enable=0.
    - On cfg_valid & cfg_ready: latch cfg_word into the shift register, clear the word bit counter, go to SHIFT.
  - SHIFT: each cycle configuration_enable=1, configuration_input=sreg[0]; then sreg shifts right, word bit counter +1, bit_count +1.
    - Bit that brings bit_count to CHAIN_LENGTH → DONE. This takes priority over word exhaustion.
    - Else, WORD_WIDTH-th bit of the word → LOAD.
    - Else remain in SHIFT.
  - DONE: done=1 for exactly one cycle, configuration_enable=0 → IDLE.
- Latency: word accepted on edge N → its bit 0 appears with configuration_enable=1 in cycle N+1.
- Bubbles: one bubble cycle (enable low) per word boundary. While cfg_valid=0 in LOAD, enable stays low for as long as it takes; the chain holds its contents.
- Partial last word: when CHAIN_LENGTH mod WORD_WIDTH ≠ 0, the unused high bits of the last word are discarded and never shifted.
- cfg_ready is 0 in IDLE, SHIFT and DONE. Words offered there are not consumed.
- start while busy: ignored.
- start and abort together in IDLE: abort wins, stay IDLE.
- abort in LOAD/SHIFT/DONE: next edge → IDLE, configuration_enable=0, cfg_ready=0.
  - No done pulse is produced.
  - bit_count holds its last value until the next start.
  - Chain contents are left partial; the controller must reload.
- Reset mid-load: same effect as abort, plus all outputs go to their reset values immediately (async).
- bit_count never exceeds CHAIN_LENGTH; it holds its value in IDLE after DONE.

Decomposition:
- Shared package dsp_cfg_pkg:
  - state enum: IDLE, LOAD, SHIFT, DONE (2-bit encoding).
  - CNT_W derivation function.
  - default CHAIN_LENGTH constant, kept next to the slice's chain-length constant.
- No sub-module: FSM, shift register and two counters stay in one block.

Test Plan:
1. CHAIN_LENGTH=20, WORD_WIDTH=8; start, then words 0xA5, 0x3C, 0x0F with no stall.
   - Serial stream with enable high: 1,0,1,0,0,1,0,1 | 0,0,1,1,1,1,0,0 | 1,1,1,1.
   - Exactly 20 enable-high cycles, one bubble after each of the first two words.
   - done pulses once, bit_count=20, busy drops after DONE.
2. cfg_valid withheld 5 cycles before the second word.
   - configuration_enable stays 0 for those 5 cycles; the stream is otherwise identical to scenario 1.
3. abort asserted when bit_count=11.
   - Next cycle: state IDLE, enable=0, done never pulses, bit_count=11.
   - A fresh start restarts bit_count from 0.
4. reset_n pulled low mid-SHIFT, asynchronously to clk.
   - All outputs 0 without waiting for a clock edge.
   - After release, start plus scenario-1 words reproduce the scenario-1 stream.
5. start pulsed during SHIFT, and cfg_valid held high in IDLE with cfg_word=0xFF.
   - No restart occurs and no word is consumed (cfg_ready=0).
6. CHAIN_LENGTH=16, WORD_WIDTH=16, single word 0x8001.
   - First bit 1, 14 zeros, last bit 1.
   - DONE entered straight from SHIFT with no extra LOAD visit.
